// File: rtl/newton_step_invsqrt.sv
// Newton-Raphson refinement of a fast inverse-square-root estimate:
// y <- y*(c - h*y*y), ITER passes through one shared FP32 multiplier and subtractor.
//
// state  | meaning
// IDLE   | waiting for an operand triple, in_ready high
// MUL_YY | t <- y*y
// MUL_HT | t <- h*t
// SUB    | t <- c-t
// MUL_YT | y <- y*t, loop or finish
// DONE   | result presented until out_ready
module newton_step_invsqrt #(
    parameter int ITER = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] y0_in,
    input  logic [31:0] half_x_in,
    input  logic [31:0] three_half_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MUL_YY = 3'd1,
        MUL_HT = 3'd2,
        SUB    = 3'd3,
        MUL_YT = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] LAST = 2'(ITER - 1);

    state_t      state, state_nxt;
    logic [31:0] y, h, c, t;
    logic [1:0]  cnt;
    logic [31:0] mul_a, mul_b, mul_p, sub_r;

    // Truncating FP32 multiply; denormal inputs and underflow give +0.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [24:0]       hi;
        logic signed [9:0] e;
        logic [22:0]       man;
        logic [31:0]       r;
        hi = 25'((48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]})) >> 23);
        e  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (hi[24]) begin
            man = hi[23:1];
            e   = e + 10'sd1;
        end else begin
            man = hi[22:0];
        end
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 10'sd0)
            r = 32'h0000_0000;
        else if (e >= 10'sd255)
            r = 32'h7F7F_FFFF;
        else
            r = {a[31] ^ b[31], e[7:0], man};
        return r;
    endfunction

    function automatic logic [4:0] lzc24(input logic [23:0] m);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Truncating FP32 a-b by sign-magnitude add; zero-exponent operands count as 0.
    function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
        logic              sa, sb, sl, ss;
        logic [23:0]       ma, mb, ml, ms, ms_al;
        logic [7:0]        el, es, sh;
        logic [24:0]       mag;
        logic [4:0]        lz;
        logic signed [9:0] e;
        logic [22:0]       man;
        logic [31:0]       r;
        sa = a[31];
        sb = ~b[31];
        ma = (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
        mb = (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
        if ({a[30:23], ma} >= {b[30:23], mb}) begin
            el = a[30:23]; ml = ma; sl = sa;
            es = b[30:23]; ms = mb; ss = sb;
        end else begin
            el = b[30:23]; ml = mb; sl = sb;
            es = a[30:23]; ms = ma; ss = sa;
        end
        sh    = el - es;
        ms_al = (sh >= 8'd25) ? 24'd0 : (ms >> sh);
        if (sl == ss) mag = {1'b0, ml} + {1'b0, ms_al};
        else          mag = {1'b0, ml - ms_al};
        lz = lzc24(mag[23:0]);
        if (mag[24]) begin
            man = mag[23:1];
            e   = $signed({2'b00, el}) + 10'sd1;
        end else begin
            man = 23'(mag[22:0] << lz);
            e   = $signed({2'b00, el}) - $signed({5'b00000, lz});
        end
        if (mag == 25'd0 || e <= 10'sd0)
            r = 32'h0000_0000;
        else if (e >= 10'sd255)
            r = {sl, 31'h7F7F_FFFF};
        else
            r = {sl, e[7:0], man};
        return r;
    endfunction

    always_comb begin
        mul_a = y;
        mul_b = y;
        case (state)
            MUL_HT: begin
                mul_a = h;
                mul_b = t;
            end
            MUL_YT: mul_b = t;
            default: ;
        endcase
    end

    assign mul_p = fp_mul(mul_a, mul_b);
    assign sub_r = fp_sub(c, t);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MUL_YY;
            MUL_YY:  state_nxt = MUL_HT;
            MUL_HT:  state_nxt = SUB;
            SUB:     state_nxt = MUL_YT;
            MUL_YT:  state_nxt = (cnt == LAST) ? DONE : MUL_YY;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        y_out     = (state == DONE) ? y : 32'h0000_0000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y   <= 32'h0;
            h   <= 32'h0;
            c   <= 32'h0;
            t   <= 32'h0;
            cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        y   <= y0_in;
                        h   <= half_x_in;
                        c   <= three_half_in;
                        cnt <= 2'd0;
                    end
                end
                MUL_YY, MUL_HT: t <= mul_p;
                SUB:            t <= sub_r;
                MUL_YT: begin
                    y <= mul_p;
                    if (cnt != LAST) cnt <= cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_newton_step_invsqrt.sv
// Directed bench for newton_step_invsqrt: one instance with ITER=1, one with ITER=2.
module tb_newton_step_invsqrt;

    localparam logic [31:0] X4_Y0   = 32'h3EF7_59DF;
    localparam logic [31:0] X4_HX   = 32'h4000_0000;
    localparam logic [31:0] C15     = 32'h3FC0_0000;
    localparam logic [31:0] ONE     = 32'h3F80_0000;
    localparam logic [31:0] HALF    = 32'h3F00_0000;
    // Exact truncated results for x=4 after one and two steps (0.499153, 0.4999978).
    localparam logic [31:0] Y1_X4   = 32'h3EFF_9110;
    localparam logic [31:0] Y2_X4   = 32'h3EFF_FFB7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] y0, hx, ch;
    logic        iv1, ir1, ov1, or1;
    logic [31:0] yo1;
    logic        iv2, ir2, ov2, or2;
    logic [31:0] yo2;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    newton_step_invsqrt #(.ITER(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1),
        .y0_in(y0), .half_x_in(hx), .three_half_in(ch),
        .out_valid(ov1), .out_ready(or1), .y_out(yo1)
    );

    newton_step_invsqrt #(.ITER(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(iv2), .in_ready(ir2),
        .y0_in(y0), .half_x_in(hx), .three_half_in(ch),
        .out_valid(ov2), .out_ready(or2), .y_out(yo2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_acc, n_res;
        int          acc_cyc [2];
        logic [31:0] res [2];
        logic        acc, got;

        iv1 = 1'b0; or1 = 1'b0; iv2 = 1'b0; or2 = 1'b1;
        y0 = 32'h0; hx = 32'h0; ch = 32'h0;

        repeat (2) tick();
        check("rst_in_ready", 32'(ir1), 32'd1);
        check("rst_out_valid", 32'(ov1), 32'd0);
        check("rst_y_out", yo1, 32'h0);
        rst = 1'b1;
        tick();

        // single step, latency 4
        y0 = X4_Y0; hx = X4_HX; ch = C15; iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        check("busy_in_ready", 32'(ir1), 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("lat1_early_valid", 32'(ov1), 32'd0);
        end
        tick();
        check("lat1_valid", 32'(ov1), 32'd1);
        check("step1_x4", yo1, Y1_X4);

        // backpressure with an ignored in_valid pulse
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                iv1 = 1'b1; y0 = ONE; hx = HALF;
            end else begin
                iv1 = 1'b0;
            end
            tick();
            check("bp_out_valid", 32'(ov1), 32'd1);
            check("bp_y_out", yo1, Y1_X4);
            check("bp_in_ready", 32'(ir1), 32'd0);
        end
        iv1 = 1'b0;
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
        check("release_out_valid", 32'(ov1), 32'd0);
        check("release_in_ready", 32'(ir1), 32'd1);
        tick();
        check("no_capture_in_ready", 32'(ir1), 32'd1);
        check("no_capture_out_valid", 32'(ov1), 32'd0);

        // zero estimate
        y0 = 32'h0; hx = X4_HX; ch = C15; iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        or1 = 1'b1;
        repeat (3) tick();
        check("zero_early_valid", 32'(ov1), 32'd0);
        tick();
        check("zero_valid", 32'(ov1), 32'd1);
        check("zero_y_out", yo1, 32'h0);
        tick();
        check("zero_back_idle", 32'(ir1), 32'd1);
        or1 = 1'b0;

        // reset two cycles after accept
        y0 = X4_Y0; hx = X4_HX; ch = C15; iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(ov1), 32'd0);
        check("rst_mid_y_out", yo1, 32'h0);
        check("rst_mid_in_ready", 32'(ir1), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        y0 = X4_Y0; hx = X4_HX; ch = C15; iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        repeat (4) tick();
        check("after_rst_valid", 32'(ov1), 32'd1);
        check("after_rst_y_out", yo1, Y1_X4);

        // reset while presenting a result
        rst = 1'b0;
        #1;
        check("rst_done_out_valid", 32'(ov1), 32'd0);
        check("rst_done_y_out", yo1, 32'h0);
        check("rst_done_in_ready", 32'(ir1), 32'd1);
        tick();
        rst = 1'b1;
        tick();

        // two steps, latency 8
        y0 = X4_Y0; hx = X4_HX; ch = C15; iv2 = 1'b1;
        tick();
        iv2 = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            check("lat2_early_valid", 32'(ov2), 32'd0);
        end
        tick();
        check("lat2_valid", 32'(ov2), 32'd1);
        check("step2_x4", yo2, Y2_X4);
        tick();
        check("step2_back_idle", 32'(ir2), 32'd1);

        // back-to-back triples with out_ready held high
        or1 = 1'b1;
        y0 = X4_Y0; hx = X4_HX; ch = C15; iv1 = 1'b1;
        n_acc = 0; n_res = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        res[0] = 32'h0; res[1] = 32'h0;
        for (int cyc = 0; cyc < 40 && n_res < 2; cyc++) begin
            acc = iv1 && ir1;
            got = ov1 && or1;
            if (got && n_res < 2) begin
                res[n_res] = yo1;
                n_res++;
            end
            tick();
            if (acc && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    y0 = ONE; hx = HALF; ch = C15;
                end else begin
                    iv1 = 1'b0;
                end
            end
        end
        iv1 = 1'b0;
        check("b2b_accepts", 32'(n_acc), 32'd2);
        check("b2b_results", 32'(n_res), 32'd2);
        check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
        check("b2b_first", res[0], Y1_X4);
        check("b2b_second", res[1], ONE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
